// File: rtl/sequencer_key_frontend.sv
// Sequencer-mode keypad front end: per-key sync/debounce lanes, step toggle
// pulses, mode and play/pause latches, and a tempo short/long/repeat classifier.

// One key lane: two-flop synchroniser, counter debounce, previous-value register.
module skf_key_lane #(
  parameter int DEBOUNCE_CYCLES = 20
) (
  input  logic clk,
  input  logic n_rst,
  input  logic raw,
  output logic deb,
  output logic deb_prev
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          s1, sync;
  logic [CW-1:0] cnt;

  // Accept a new level only after DEBOUNCE_CYCLES consecutive mismatching samples.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      s1       <= 1'b0;
      sync     <= 1'b0;
      deb      <= 1'b0;
      deb_prev <= 1'b0;
      cnt      <= '0;
    end else begin
      s1       <= raw;
      sync     <= s1;
      deb_prev <= deb;
      if (sync == deb) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        deb <= sync;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module sequencer_key_frontend #(
  parameter int NUM_STEPS       = 8,
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int HOLD_CYCLES     = 5000,
  parameter int REPEAT_CYCLES   = 1000
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic [NUM_STEPS+2:0] keys,
  output logic [NUM_STEPS-1:0] toggle,
  output logic                 sequencer_on,
  output logic                 play,
  output logic                 tempo_button,
  output logic                 tempo_hold
);
  localparam int NK        = NUM_STEPS + 3;
  localparam int KEY_PLAY  = 0;
  localparam int KEY_MODE  = 1;
  localparam int KEY_TEMPO = NUM_STEPS + 2;
  localparam int HW        = $clog2(HOLD_CYCLES + 1);
  localparam int RW        = $clog2(REPEAT_CYCLES + 1);

  typedef enum logic [1:0] {T_IDLE, T_PRESSED, T_LONG} tstate_t;

  logic [NK-1:0] deb, deb_prev, rise;
  logic          tempo_fall;
  logic          seq_d, play_d;
  tstate_t       st_q, st_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [RW-1:0] rcnt_q, rcnt_d;

  for (genvar g = 0; g < NK; g++) begin : g_lane
    skf_key_lane #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lane (
      .clk      (clk),
      .n_rst    (n_rst),
      .raw      (keys[g]),
      .deb      (deb[g]),
      .deb_prev (deb_prev[g])
    );
  end

  assign rise       = deb & ~deb_prev;
  assign tempo_fall = ~deb[KEY_TEMPO] & deb_prev[KEY_TEMPO];

  // Step i lives on key bit 2+i; pulses are suppressed in piano mode.
  assign toggle = rise[NUM_STEPS+1:2] & {NUM_STEPS{sequencer_on}};

  // Mode flips on its rise; play only toggles while already in sequencer mode
  // and is cleared whenever the mode is (or is about to be) off.
  always_comb begin
    seq_d  = sequencer_on ^ rise[KEY_MODE];
    play_d = play;
    if (!seq_d)
      play_d = 1'b0;
    else if (sequencer_on && rise[KEY_PLAY])
      play_d = ~play;
  end

  // Mode and play latches.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sequencer_on <= 1'b0;
      play         <= 1'b0;
    end else begin
      sequencer_on <= seq_d;
      play         <= play_d;
    end
  end

  // Tempo classifier: short press reports on release, long press reports at
  // the hold threshold and then every REPEAT_CYCLES+1 cycles while held.
  always_comb begin
    st_d         = st_q;
    hcnt_d       = hcnt_q;
    rcnt_d       = rcnt_q;
    tempo_button = 1'b0;
    tempo_hold   = 1'b0;
    case (st_q)
      T_IDLE: begin
        if (rise[KEY_TEMPO]) begin
          st_d   = T_PRESSED;
          hcnt_d = HW'(1);
        end
      end
      T_PRESSED: begin
        if (tempo_fall) begin
          tempo_button = 1'b1;
          st_d         = T_IDLE;
        end else if (deb[KEY_TEMPO]) begin
          hcnt_d = hcnt_q + 1'b1;
          if (hcnt_q == HW'(HOLD_CYCLES - 1)) begin
            tempo_hold = 1'b1;
            st_d       = T_LONG;
            rcnt_d     = '0;
          end
        end
      end
      T_LONG: begin
        if (tempo_fall) begin
          st_d = T_IDLE;
        end else if (rcnt_q == RW'(REPEAT_CYCLES)) begin
          tempo_hold = 1'b1;
          rcnt_d     = '0;
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
      default: st_d = T_IDLE;
    endcase
  end

  // Tempo classifier state and counters.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      st_q   <= T_IDLE;
      hcnt_q <= '0;
      rcnt_q <= '0;
    end else begin
      st_q   <= st_d;
      hcnt_q <= hcnt_d;
      rcnt_q <= rcnt_d;
    end
  end
endmodule

// File: tb/tb_sequencer_key_frontend.sv
// Directed bench for sequencer_key_frontend with short debounce/hold timings.
module tb_sequencer_key_frontend;
  localparam int NS = 8;
  localparam int NK = NS + 3;
  localparam logic [NK-1:0] K_PLAY  = 11'h001;
  localparam logic [NK-1:0] K_MODE  = 11'h002;
  localparam logic [NK-1:0] K_STEP3 = 11'h020;
  localparam logic [NK-1:0] K_S07   = 11'h204;
  localparam logic [NK-1:0] K_TEMPO = 11'h400;

  logic          clk = 1'b0;
  logic          n_rst;
  logic [NK-1:0] keys;
  logic [NS-1:0] toggle;
  logic          sequencer_on, play, tempo_button, tempo_hold;

  sequencer_key_frontend #(
    .NUM_STEPS(NS), .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(10), .REPEAT_CYCLES(3)
  ) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .keys         (keys),
    .toggle       (toggle),
    .sequencer_on (sequencer_on),
    .play         (play),
    .tempo_button (tempo_button),
    .tempo_hold   (tempo_hold)
  );

  always #5 clk = ~clk;

  int            tests = 0, fails = 0;
  int            tog_n, tog_at, btn_n, btn_at, hold_n;
  int            hold_at[8];
  logic [NS-1:0] tog_or;

  typedef struct {
    logic [NK-1:0] k;
    int            cyc;
    logic          seq;
    logic          ply;
    logic [NS-1:0] tog;
    int            tog_n;
  } vec_t;
  vec_t tbl[12];

  task automatic chk(input string nm, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    tog_n = 0; tog_at = -1; btn_n = 0; btn_at = -1; hold_n = 0; tog_or = '0;
    for (int i = 0; i < 8; i++) hold_at[i] = -1;
  endtask

  task automatic sample(input int t);
    if (toggle != '0) begin tog_n++; tog_at = t; end
    tog_or = tog_or | toggle;
    if (tempo_button) begin btn_n++; btn_at = t; end
    if (tempo_hold) begin
      if (hold_n < 8) hold_at[hold_n] = t;
      hold_n++;
    end
  endtask

  // Drive kv, drop keys to 0 after on_t ticks, observe tot ticks.
  task automatic run(input logic [NK-1:0] kv, input int on_t, input int tot);
    clear_mon();
    keys = kv;
    for (int t = 1; t <= tot; t++) begin
      tick();
      sample(t);
      if (t == on_t) keys = '0;
    end
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    keys  = '0;
    tick();
    tick();
    n_rst = 1'b1;
  endtask

  initial begin
    tbl[0]  = '{K_STEP3, 8, 1'b0, 1'b0, 8'h00, 0};
    tbl[1]  = '{'0,      8, 1'b0, 1'b0, 8'h00, 0};
    tbl[2]  = '{K_PLAY,  8, 1'b0, 1'b0, 8'h00, 0};
    tbl[3]  = '{'0,      8, 1'b0, 1'b0, 8'h00, 0};
    tbl[4]  = '{K_MODE,  8, 1'b1, 1'b0, 8'h00, 0};
    tbl[5]  = '{'0,      8, 1'b1, 1'b0, 8'h00, 0};
    tbl[6]  = '{K_PLAY,  8, 1'b1, 1'b1, 8'h00, 0};
    tbl[7]  = '{'0,      8, 1'b1, 1'b1, 8'h00, 0};
    tbl[8]  = '{K_STEP3, 8, 1'b1, 1'b1, 8'h08, 1};
    tbl[9]  = '{'0,      8, 1'b1, 1'b1, 8'h00, 0};
    tbl[10] = '{K_S07,   8, 1'b1, 1'b1, 8'h81, 1};
    tbl[11] = '{'0,      8, 1'b1, 1'b1, 8'h00, 0};

    // Reset with every key held
    n_rst = 1'b0;
    keys  = '1;
    tick();
    tick();
    chk("rst_toggle", int'(toggle), 0);
    chk("rst_seq", int'(sequencer_on), 0);
    chk("rst_play", int'(play), 0);
    chk("rst_tbtn", int'(tempo_button), 0);
    chk("rst_thold", int'(tempo_hold), 0);

    // Mode held through reset release: latch flips at edge 6
    keys  = K_MODE;
    tick();
    n_rst = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    chk("rst_mode_edge5", int'(sequencer_on), 0);
    tick();
    chk("rst_mode_edge6", int'(sequencer_on), 1);
    run('0, 10, 10);

    // Table: mode gating, play latch, step pulses
    do_reset();
    for (int i = 0; i < 12; i++) begin
      run(tbl[i].k, tbl[i].cyc, tbl[i].cyc);
      if (tbl[i].k == '0) keys = '0;
      chk($sformatf("vec%0d_seq", i), int'(sequencer_on), int'(tbl[i].seq));
      chk($sformatf("vec%0d_play", i), int'(play), int'(tbl[i].ply));
      chk($sformatf("vec%0d_togor", i), int'(tog_or), int'(tbl[i].tog));
      chk($sformatf("vec%0d_togn", i), tog_n, tbl[i].tog_n);
    end

    // Mode off clears play on the same edge
    keys = K_MODE;
    for (int i = 0; i < 6; i++) tick();
    chk("modeoff_pre_seq", int'(sequencer_on), 1);
    chk("modeoff_pre_play", int'(play), 1);
    tick();
    chk("modeoff_seq", int'(sequencer_on), 0);
    chk("modeoff_play", int'(play), 0);
    run('0, 10, 10);

    // Mode and play in the same cycle from reset
    do_reset();
    run(K_MODE | K_PLAY, 8, 8);
    chk("simul_seq", int'(sequencer_on), 1);
    chk("simul_play", int'(play), 0);
    run('0, 10, 10);

    // Bounce 1,0,1,1,... on step 3 with sequencer on
    clear_mon();
    keys = K_STEP3;
    tick(); sample(1);
    keys = '0;
    tick(); sample(2);
    keys = K_STEP3;
    for (int t = 3; t <= 14; t++) begin tick(); sample(t); end
    chk("bounce_n", tog_n, 1);
    chk("bounce_at", tog_at, 8);
    chk("bounce_val", int'(tog_or), 8'h08);
    run('0, 10, 10);

    // 3-cycle glitch is rejected
    run(K_STEP3, 3, 14);
    chk("glitch_n", tog_n, 0);

    // Tempo short press
    do_reset();
    run(K_TEMPO, 6, 20);
    chk("short_btn_n", btn_n, 1);
    chk("short_btn_at", btn_at, 12);
    chk("short_hold_n", hold_n, 0);

    // Tempo long press with repeats
    run(K_TEMPO, 20, 32);
    chk("long_hold_n", hold_n, 3);
    chk("long_hold0", hold_at[0], 15);
    chk("long_hold1", hold_at[1], 19);
    chk("long_hold2", hold_at[2], 23);
    chk("long_btn_n", btn_n, 0);

    // Reset mid-hold, key kept down: fresh press timing afterwards
    keys = K_TEMPO;
    for (int i = 0; i < 17; i++) tick();
    n_rst = 1'b0;
    #1;
    chk("midrst_toggle", int'(toggle), 0);
    chk("midrst_seq", int'(sequencer_on), 0);
    chk("midrst_play", int'(play), 0);
    chk("midrst_tbtn", int'(tempo_button), 0);
    chk("midrst_thold", int'(tempo_hold), 0);
    tick();
    tick();
    n_rst = 1'b1;
    run(K_TEMPO, 40, 30);
    chk("midrst_hold0", hold_at[0], 15);
    chk("midrst_hold_n", hold_n, 4);
    chk("midrst_btn_n", btn_n, 0);
    keys = '0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
